rv32i_control_unit: RTL and testbench
=====================================

Name: rv32i_control_unit

Overview:
- Main decoder of the single-cycle RV32I core. From the current instruction word and the branch-comparator flags, it produces the datapath selects, write enables, the ALU operation and instruction validity.
- Decode is combinational from i_instr; one registered reset-hold flag suppresses side effects while and right after reset.

Parameters:
- None.

Ports:
- i_clk  input  1  core clock, rising edge
- i_rst  input  1  synchronous active-high reset
- i_instr  input  32  current instruction word
- i_brc_less  input  1  rs1 < rs2 from the branch comparator (signedness per o_br_un)
- i_brc_equal  input  1  rs1 == rs2 from the branch comparator
- o_pc_sel  output  1  0 = PC+4, 1 = ALU result (jump/taken branch)
- o_rd_wren  output  1  register-file write enable
- o_insn_vld  output  1  instruction is legal RV32I
- o_br_un  output  1  1 = unsigned branch compare
- o_opa_sel  output  1  ALU A: 0 = rs1, 1 = PC
- o_opb_sel  output  1  ALU B: 0 = rs2, 1 = immediate
- o_mem_wren  output  1  data-memory write enable
- o_wb_sel  output  2  writeback: 00 = PC+4, 01 = ALU, 10 = load data, 11 unused
- o_alu_op  output  4  ALU operation code

Behaviour:
- ALU codes:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU
  - 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND
  - 1111 pass B
- Decode by opcode i_instr[6:0], funct3 [14:12], funct7 [31:25]:
  - R 0110011: rd_wren=1, opa=0, opb=0, wb=01. alu_op from funct3/funct7; funct7 must be 0000000, or 0100000 only for SUB/SRA.
  - I-ALU 0010011: rd_wren=1, opb=1, wb=01. alu_op from funct3 (no SUB). Shifts require funct7 0000000, or 0100000 for SRAI.
  - LOAD 0000011: rd_wren=1, opb=1, alu ADD, wb=10. funct3 must be in {000,001,010,100,101}.
  - STORE 0100011: mem_wren=1, opb=1, alu ADD. funct3 must be in {000,001,010}.
  - BRANCH 1100011: opa=1, opb=1, alu ADD, rd_wren=0. Legal funct3 in {000,001,100,101,110,111}; br_un=1 for 110/111.
    - Taken conditions: BEQ eq; BNE !eq; BLT/BLTU less; BGE/BGEU !less.
    - o_pc_sel=1 iff the branch is taken.
  - JAL 1101111: opa=1, opb=1, alu ADD, rd_wren=1, wb=00, pc_sel=1.
  - JALR 1100111: funct3 must be 000. opa=0, opb=1, alu ADD, rd_wren=1, wb=00, pc_sel=1.
  - LUI 0110111: opb=1, alu 1111, rd_wren=1, wb=01.
  - AUIPC 0010111: opa=1, opb=1, alu ADD, rd_wren=1, wb=01.
- Legal instructions drive o_insn_vld=1.
- Defaults for any field not listed: pc_sel=0, rd_wren=0, mem_wren=0, br_un=0, opa=0, opb=0, wb=01, alu_op=0000.
- Illegal instruction (unknown opcode, or bad funct3/funct7): insn_vld=0 and all defaults. The branch flags are ignored.
- rd=x0 does not suppress o_rd_wren; the register file ignores x0 writes.
- Reset-hold flag:
  - Set on a rising edge with i_rst=1.
  - Cleared on the first rising edge with i_rst=0.
  - While set: o_rd_wren, o_mem_wren, o_pc_sel and o_insn_vld are forced to 0. Other outputs still follow the decode.
- Assertion of i_rst mid-operation takes effect only at the next edge; no asynchronous path exists.
- Outside reset-hold, output changes follow i_instr or branch-flag changes combinationally, with zero latency.

Test Plan:
- Hold i_rst=1 for 2 edges, i_instr=0x00000033 -> rd_wren=0, insn_vld=0, alu_op=0000. Release; after 1 edge -> rd_wren=1, insn_vld=1.
- Load and store decode:
  - 0x00000003 (LB) -> rd_wren=1, mem_wren=0, alu_op=0000, opb=1, wb=10.
  - 0x00000023 (SB) -> rd_wren=0, mem_wren=1, alu_op=0000.
- Branches:
  - 0x00000063 (BEQ), brc_equal=1 -> pc_sel=1; brc_equal=0 -> pc_sel=0.
  - 0x00006063 (BLTU), less=1 -> pc_sel=1, br_un=1.
- R-type ALU ops:
  - 0x00000033 (ADD) -> alu_op=0000, rd_wren=1, wb=01.
  - 0x40000033 (SUB) -> alu_op=0001.
  - 0x40005033 (SRA) -> alu_op=0111.
- Jumps and LUI:
  - JAL 0x0000006F -> pc_sel=1, wb=00, opa=1.
  - JALR 0x00000067 -> pc_sel=1, opa=0.
  - LUI 0x00000037 -> alu_op=1111.
- Illegal instructions:
  - 0x000000C3 with brc_equal=1 -> insn_vld=0, pc_sel=0, rd_wren=0, mem_wren=0.
  - 0x02000033 -> insn_vld=0.

Source files
------------

// File: rtl/rv32i_control_unit_if.sv
// Instruction/flag inputs and decoded control outputs of the RV32I main decoder.
// The core side (master) drives the instruction; the decoder (slave) returns controls.
interface rv32i_control_unit_if;
    logic [31:0] i_instr;
    logic        i_brc_less;
    logic        i_brc_equal;
    logic        o_pc_sel;
    logic        o_rd_wren;
    logic        o_insn_vld;
    logic        o_br_un;
    logic        o_opa_sel;
    logic        o_opb_sel;
    logic        o_mem_wren;
    logic [1:0]  o_wb_sel;
    logic [3:0]  o_alu_op;

    modport master (
        output i_instr, i_brc_less, i_brc_equal,
        input  o_pc_sel, o_rd_wren, o_insn_vld, o_br_un, o_opa_sel,
               o_opb_sel, o_mem_wren, o_wb_sel, o_alu_op
    );

    modport slave (
        input  i_instr, i_brc_less, i_brc_equal,
        output o_pc_sel, o_rd_wren, o_insn_vld, o_br_un, o_opa_sel,
               o_opb_sel, o_mem_wren, o_wb_sel, o_alu_op
    );
endinterface

// File: rtl/rv32i_control_unit.sv
// Combinational RV32I main decoder; a registered reset-hold flag masks all
// state-changing outputs while, and for one edge after, reset is asserted.
module rv32i_control_unit (
    input  logic                  i_clk,
    input  logic                  i_rst,
    rv32i_control_unit_if.slave   bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic       rst_hold_q;
    logic       rst_hold_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    logic       pc_sel;
    logic       rd_wren;
    logic       insn_vld;
    logic       br_un;
    logic       opa_sel;
    logic       opb_sel;
    logic       mem_wren;
    logic [1:0] wb_sel;
    logic [3:0] alu_op;
    logic [3:0] alu_base;
    logic       br_taken;

    assign opcode = bus.i_instr[6:0];
    assign funct3 = bus.i_instr[14:12];
    assign funct7 = bus.i_instr[31:25];
    assign unused_instr_bits = ^{bus.i_instr[24:15], bus.i_instr[11:7]};

    // Reset-hold is a plain copy of i_rst taken at each edge.
    assign rst_hold_d = i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rst_hold_q <= 1'b1;
        end else begin
            rst_hold_q <= rst_hold_d;
        end
    end

    // Shared funct3 -> ALU mapping for R-type and I-type arithmetic.
    always_comb begin
        alu_base = ALU_ADD;
        case (funct3)
            3'b000: alu_base = ALU_ADD;
            3'b001: alu_base = 4'b0010;
            3'b010: alu_base = 4'b0011;
            3'b011: alu_base = 4'b0100;
            3'b100: alu_base = 4'b0101;
            3'b101: alu_base = 4'b0110;
            3'b110: alu_base = 4'b1000;
            3'b111: alu_base = 4'b1001;
            default: alu_base = ALU_ADD;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:         br_taken = bus.i_brc_equal;
            3'b001:         br_taken = ~bus.i_brc_equal;
            3'b100, 3'b110: br_taken = bus.i_brc_less;
            3'b101, 3'b111: br_taken = ~bus.i_brc_less;
            default:        br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_sel   = 1'b0;
        rd_wren  = 1'b0;
        insn_vld = 1'b0;
        br_un    = 1'b0;
        opa_sel  = 1'b0;
        opb_sel  = 1'b0;
        mem_wren = 1'b0;
        wb_sel   = 2'b01;
        alu_op   = ALU_ADD;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_ZERO) begin
                    insn_vld = 1'b1;
                    rd_wren  = 1'b1;
                    alu_op   = alu_base;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    insn_vld = 1'b1;
                    rd_wren  = 1'b1;
                    alu_op   = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    insn_vld = 1'b1;
                    rd_wren  = 1'b1;
                    alu_op   = ALU_SRA;
                end
            end
            OP_I: begin
                // funct7 only constrains the shift-immediate forms.
                if (funct3 == 3'b001) begin
                    insn_vld = (funct7 == F7_ZERO);
                    alu_op   = alu_base;
                end else if (funct3 == 3'b101) begin
                    insn_vld = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    alu_op   = (funct7 == F7_ALT) ? ALU_SRA : alu_base;
                end else begin
                    insn_vld = 1'b1;
                    alu_op   = alu_base;
                end
                rd_wren = insn_vld;
                opb_sel = insn_vld;
                if (!insn_vld) begin
                    alu_op = ALU_ADD;
                end
            end
            OP_LOAD: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    insn_vld = 1'b1;
                    rd_wren  = 1'b1;
                    opb_sel  = 1'b1;
                    wb_sel   = 2'b10;
                end
            end
            OP_STORE: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
                    insn_vld = 1'b1;
                    mem_wren = 1'b1;
                    opb_sel  = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    insn_vld = 1'b1;
                    opa_sel  = 1'b1;
                    opb_sel  = 1'b1;
                    br_un    = funct3[2] & funct3[1];
                    pc_sel   = br_taken;
                end
            end
            OP_JAL: begin
                insn_vld = 1'b1;
                rd_wren  = 1'b1;
                opa_sel  = 1'b1;
                opb_sel  = 1'b1;
                wb_sel   = 2'b00;
                pc_sel   = 1'b1;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    insn_vld = 1'b1;
                    rd_wren  = 1'b1;
                    opb_sel  = 1'b1;
                    wb_sel   = 2'b00;
                    pc_sel   = 1'b1;
                end
            end
            OP_LUI: begin
                insn_vld = 1'b1;
                rd_wren  = 1'b1;
                opb_sel  = 1'b1;
                alu_op   = ALU_PASSB;
            end
            OP_AUIPC: begin
                insn_vld = 1'b1;
                rd_wren  = 1'b1;
                opa_sel  = 1'b1;
                opb_sel  = 1'b1;
            end
            default: begin
                insn_vld = 1'b0;
            end
        endcase
    end

    assign bus.o_pc_sel   = pc_sel   & ~rst_hold_q;
    assign bus.o_rd_wren  = rd_wren  & ~rst_hold_q;
    assign bus.o_mem_wren = mem_wren & ~rst_hold_q;
    assign bus.o_insn_vld = insn_vld & ~rst_hold_q;
    assign bus.o_br_un    = br_un;
    assign bus.o_opa_sel  = opa_sel;
    assign bus.o_opb_sel  = opb_sel;
    assign bus.o_wb_sel   = wb_sel;
    assign bus.o_alu_op   = alu_op;
endmodule

// File: tb/tb_rv32i_control_unit.sv
// Scoreboard bench for the RV32I decoder: stimulus pushes hand-computed control
// vectors, a negedge monitor pops and compares them against the live outputs.
module tb_rv32i_control_unit;
    logic clk;
    logic rst;

    rv32i_control_unit_if bus ();

    rv32i_control_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed order: pc, rd, vld, br_un, opa, opb, mem, wb[1:0], alu[3:0]
    typedef struct {
        logic [12:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb_q[$];
    int total = 0;
    int bad   = 0;
    bit stim_done = 1'b0;

    task automatic vec(input logic [31:0] instr, input logic less, input logic eq,
                       input logic r, input logic [12:0] exp, input string name);
        sb_item_t it;
        @(posedge clk);
        #1;
        rst             = r;
        bus.i_instr     = instr;
        bus.i_brc_less  = less;
        bus.i_brc_equal = eq;
        it.exp  = exp;
        it.name = name;
        sb_q.push_back(it);
    endtask

    always @(negedge clk) begin
        logic [12:0] act;
        sb_item_t    it;
        if (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            act = {bus.o_pc_sel, bus.o_rd_wren, bus.o_insn_vld, bus.o_br_un,
                   bus.o_opa_sel, bus.o_opb_sel, bus.o_mem_wren,
                   bus.o_wb_sel, bus.o_alu_op};
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %s: got=%b want=%b (pc rd vld brun opa opb mem wb alu)",
                         it.name, act, it.exp);
            end else begin
                $display("ok   %s: %b", it.name, act);
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.i_instr     = 32'h0000_0033;
        bus.i_brc_less  = 1'b0;
        bus.i_brc_equal = 1'b0;

        // Reset hold: decode still visible, side effects masked
        vec(32'h0000_0033, 0, 0, 1, 13'b0_0_0_0_0_0_0_01_0000, "rst_edge1");
        vec(32'h0000_0033, 0, 0, 1, 13'b0_0_0_0_0_0_0_01_0000, "rst_edge2");
        vec(32'h0000_0033, 0, 0, 0, 13'b0_0_0_0_0_0_0_01_0000, "rst_released_hold");
        vec(32'h0000_0033, 0, 0, 0, 13'b0_1_1_0_0_0_0_01_0000, "add_after_rst");

        vec(32'h0000_0003, 0, 0, 0, 13'b0_1_1_0_0_1_0_10_0000, "lb");
        vec(32'h0000_0023, 0, 0, 0, 13'b0_0_1_0_0_1_1_01_0000, "sb");
        vec(32'h0000_0063, 0, 1, 0, 13'b1_0_1_0_1_1_0_01_0000, "beq_taken");
        vec(32'h0000_0063, 0, 0, 0, 13'b0_0_1_0_1_1_0_01_0000, "beq_not_taken");
        vec(32'h0000_6063, 1, 0, 0, 13'b1_0_1_1_1_1_0_01_0000, "bltu_taken");
        vec(32'h0000_6063, 0, 0, 0, 13'b0_0_1_1_1_1_0_01_0000, "bltu_not_taken");
        vec(32'h0000_1063, 0, 1, 0, 13'b0_0_1_0_1_1_0_01_0000, "bne_eq");
        vec(32'h0000_5063, 0, 0, 0, 13'b1_0_1_0_1_1_0_01_0000, "bge_taken");
        vec(32'h0000_2063, 1, 1, 0, 13'b0_0_0_0_0_0_0_01_0000, "branch_f3_010");

        vec(32'h4000_0033, 0, 0, 0, 13'b0_1_1_0_0_0_0_01_0001, "sub");
        vec(32'h4000_5033, 0, 0, 0, 13'b0_1_1_0_0_0_0_01_0111, "sra");
        vec(32'h0000_5033, 0, 0, 0, 13'b0_1_1_0_0_0_0_01_0110, "srl");
        vec(32'h0000_1033, 0, 0, 0, 13'b0_1_1_0_0_0_0_01_0010, "sll");
        vec(32'h0000_2033, 0, 0, 0, 13'b0_1_1_0_0_0_0_01_0011, "slt");
        vec(32'h0000_3033, 0, 0, 0, 13'b0_1_1_0_0_0_0_01_0100, "sltu");
        vec(32'h0000_6033, 0, 0, 0, 13'b0_1_1_0_0_0_0_01_1000, "or");
        vec(32'h0000_7033, 0, 0, 0, 13'b0_1_1_0_0_0_0_01_1001, "and");
        vec(32'h4000_4033, 0, 0, 0, 13'b0_0_0_0_0_0_0_01_0000, "r_xor_f7_alt");

        vec(32'h0000_4013, 0, 0, 0, 13'b0_1_1_0_0_1_0_01_0101, "xori");
        vec(32'h0000_3013, 0, 0, 0, 13'b0_1_1_0_0_1_0_01_0100, "sltiu");
        vec(32'h4000_5013, 0, 0, 0, 13'b0_1_1_0_0_1_0_01_0111, "srai");
        vec(32'h4000_1013, 0, 0, 0, 13'b0_0_0_0_0_0_0_01_0000, "slli_f7_alt");
        vec(32'h4000_0013, 0, 0, 0, 13'b0_1_1_0_0_1_0_01_0000, "addi_imm_hi");

        vec(32'h0000_006F, 0, 0, 0, 13'b1_1_1_0_1_1_0_00_0000, "jal");
        vec(32'h0000_0067, 0, 0, 0, 13'b1_1_1_0_0_1_0_00_0000, "jalr");
        vec(32'h0000_1067, 0, 0, 0, 13'b0_0_0_0_0_0_0_01_0000, "jalr_f3_001");
        vec(32'h0000_0037, 0, 0, 0, 13'b0_1_1_0_0_1_0_01_1111, "lui");
        vec(32'h0000_0017, 0, 0, 0, 13'b0_1_1_0_1_1_0_01_0000, "auipc");
        vec(32'h0000_3003, 0, 0, 0, 13'b0_0_0_0_0_0_0_01_0000, "load_f3_011");
        vec(32'h0000_3023, 0, 0, 0, 13'b0_0_0_0_0_0_0_01_0000, "store_f3_011");

        vec(32'h0000_00C3, 0, 1, 0, 13'b0_0_0_0_0_0_0_01_0000, "illegal_opcode");
        vec(32'h0200_0033, 0, 0, 0, 13'b0_0_0_0_0_0_0_01_0000, "illegal_mul");

        // Mid-run reset: no effect until the next edge, then masks side effects
        vec(32'h0000_0063, 0, 1, 1, 13'b1_0_1_0_1_1_0_01_0000, "rst_mid_pre_edge");
        vec(32'h0000_0063, 0, 1, 0, 13'b0_0_0_0_1_1_0_01_0000, "rst_mid_held");
        vec(32'h0000_0063, 0, 1, 0, 13'b1_0_1_0_1_1_0_01_0000, "rst_mid_released");
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (sb_q.size() > 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending want=0 pending", sb_q.size());
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
